// File: rtl/freq_error_detector.sv
// freq_error_detector: counts feedback clock edges per reference period and
// reports a saturated signed error (target - count) with a one-cycle strobe.
// Optional lock detector compiled only when FED_LOCK_DETECT_EN is defined;
// the default build ties lock_o low.
module freq_error_detector #(
  parameter int                     DYNAMIC_VAL = 1,
  parameter int                     ERROR_WIDTH = 5,
  parameter int                     COUNT_WIDTH = 8,
  parameter logic [COUNT_WIDTH-1:0] N_TARGET    = 8'd16,
  parameter int                     LOCK_TOL    = 1,
  parameter int                     LOCK_COUNT  = 4
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          ref_i,
  input  logic                          fb_i,
  input  logic [COUNT_WIDTH-1:0]        n_target_i,
  output logic signed [ERROR_WIDTH-1:0] error_o,
  output logic                          error_valid_o,
  output logic                          lock_o
);

  typedef enum logic {WAIT_REF, MEASURE} state_t;
  typedef logic signed [COUNT_WIDTH:0]   wide_t;
  typedef logic signed [ERROR_WIDTH-1:0] err_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam wide_t ERR_MAX = wide_t'((2 ** (ERROR_WIDTH - 1)) - 1);
  localparam wide_t ERR_MIN = wide_t'(-(2 ** (ERROR_WIDTH - 1)));

  // The error must fit in the signed difference of two counts.
  if (ERROR_WIDTH > COUNT_WIDTH + 1 || LOCK_COUNT < 1 || LOCK_TOL < 0) begin : g_bad_params
    $error("freq_error_detector: illegal parameter combination");
  end

  logic ref_meta, ref_sync, ref_prev, ref_pulse;
  logic fb_meta, fb_sync, fb_prev, fb_pulse;

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] count, count_next, count_closed, target;
  logic                   period_close;
  wide_t                  raw;
  err_t                   error_next;

  // Static target is a constant mux so only one source survives synthesis.
  assign target = (DYNAMIC_VAL != 0) ? n_target_i : N_TARGET;

  // Two-flop synchronizers plus registered rising-edge detectors.
  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      ref_meta  <= 1'b0;
      ref_sync  <= 1'b0;
      ref_prev  <= 1'b0;
      ref_pulse <= 1'b0;
      fb_meta   <= 1'b0;
      fb_sync   <= 1'b0;
      fb_prev   <= 1'b0;
      fb_pulse  <= 1'b0;
    end else begin
      ref_meta  <= ref_i;
      ref_sync  <= ref_meta;
      ref_prev  <= ref_sync;
      ref_pulse <= ref_sync & ~ref_prev;
      fb_meta   <= fb_i;
      fb_sync   <= fb_meta;
      fb_prev   <= fb_sync;
      fb_pulse  <= fb_sync & ~fb_prev;
    end
  end

  // Next-state logic; an fb pulse coincident with the closing ref pulse
  // belongs to the period being closed.
  always_comb begin
    state_next   = state;
    count_next   = count;
    period_close = 1'b0;
    count_closed = (fb_pulse && (count != COUNT_MAX)) ? count + 1'b1 : count;
    case (state)
      WAIT_REF: begin
        if (ref_pulse) begin
          state_next = MEASURE;
          count_next = '0;
        end
      end
      MEASURE: begin
        if (ref_pulse) begin
          period_close = 1'b1;
          count_next   = '0;
        end else begin
          count_next = count_closed;
        end
      end
      default: begin
        state_next = WAIT_REF;
        count_next = '0;
      end
    endcase
  end

  // Signed difference saturated into the error output range.
  always_comb begin
    raw = $signed({1'b0, target}) - $signed({1'b0, count_closed});
    if (raw > ERR_MAX) begin
      error_next = err_t'(ERR_MAX);
    end else if (raw < ERR_MIN) begin
      error_next = err_t'(ERR_MIN);
    end else begin
      error_next = err_t'(raw);
    end
  end

  // State, counter and registered error/strobe; error holds between strobes.
  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      state         <= WAIT_REF;
      count         <= '0;
      error_o       <= '0;
      error_valid_o <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      error_valid_o <= period_close;
      if (period_close) begin
        error_o <= error_next;
      end
    end
  end

`ifdef FED_LOCK_DETECT_EN
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);

  logic [LW-1:0] lock_cnt, lock_cnt_next;
  logic          in_tol;

  // Count consecutive in-tolerance strobes, saturating at LOCK_COUNT.
  always_comb begin
    in_tol        = (int'(error_o) <= LOCK_TOL) && (int'(error_o) >= -LOCK_TOL);
    lock_cnt_next = lock_cnt;
    if (error_valid_o) begin
      if (!in_tol) begin
        lock_cnt_next = '0;
      end else if (lock_cnt != LOCK_FULL) begin
        lock_cnt_next = lock_cnt + 1'b1;
      end
    end
  end

  // Lock register follows the counter the cycle after each strobe.
  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      lock_cnt <= '0;
      lock_o   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_next;
      lock_o   <= (lock_cnt_next == LOCK_FULL);
    end
  end
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_freq_error_detector.sv
// Self-checking bench for freq_error_detector: a scoreboard queue of expected
// errors is filled as periods are driven and drained as strobes appear.
// Lock expectations follow FED_LOCK_DETECT_EN.
module tb_freq_error_detector;

`ifdef FED_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              gen_clk = 1'b0;
  logic              reset_i;
  logic              ref_i;
  logic              fb_i;
  logic [7:0]        n_target_i;
  logic signed [4:0] error_o;
  logic              error_valid_o;
  logic              lock_o;

  int tests_run = 0;
  int tests_failed = 0;
  int strobes_seen = 0;
  int strobes_expected = 0;
  int long_strobes = 0;
  bit prev_valid = 1'b0;

  logic signed [4:0] exp_q[$];
  logic signed [4:0] obs_q[$];

  freq_error_detector dut (
    .gen_clk_i     (gen_clk),
    .reset_i       (reset_i),
    .ref_i         (ref_i),
    .fb_i          (fb_i),
    .n_target_i    (n_target_i),
    .error_o       (error_o),
    .error_valid_o (error_valid_o),
    .lock_o        (lock_o)
  );

  always #5 gen_clk = ~gen_clk;

  // Record every strobe and flag any strobe longer than one cycle.
  always @(negedge gen_clk) begin
    if (error_valid_o === 1'b1) begin
      obs_q.push_back(error_o);
      strobes_seen++;
      if (prev_valid) long_strobes++;
    end
    prev_valid = (error_valid_o === 1'b1);
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic signed [4:0] model_err(int target, int nfb);
    int c;
    int r;
    c = (nfb > 255) ? 255 : nfb;
    r = target - c;
    if (r > 15) r = 15;
    if (r < -16) r = -16;
    return 5'(r);
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge gen_clk);
  endtask

  task automatic fb_edges(int n);
    for (int i = 0; i < n; i++) begin
      fb_i = 1'b1;
      cycles(2);
      fb_i = 1'b0;
      cycles(2);
    end
  endtask

  task automatic ref_edge();
    ref_i = 1'b1;
    cycles(2);
    ref_i = 1'b0;
    cycles(2);
  endtask

  task automatic expect_err(int target, int nfb);
    exp_q.push_back(model_err(target, nfb));
    strobes_expected++;
  endtask

  task automatic do_reset(int n);
    reset_i = 1'b1;
    cycles(n);
    reset_i = 1'b0;
  endtask

  task automatic take_result(output bit seen, output logic signed [4:0] got,
                             output logic signed [4:0] exp);
    seen = 1'b0;
    got  = '0;
    exp  = '0;
    for (int k = 0; k < 16 && obs_q.size() == 0; k++) @(negedge gen_clk);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    if (obs_q.size() != 0) begin
      seen = 1'b1;
      got  = obs_q.pop_front();
    end
  endtask

  task automatic test_reset();
    ref_i = 1'b0;
    fb_i = 1'b0;
    n_target_i = 8'd16;
    do_reset(3);
    tests_run++;
    if (error_o !== 5'sd0 || error_valid_o !== 1'b0 || lock_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got err=%0d valid=%0b lock=%0b expected 0/0/0",
               error_o, error_valid_o, lock_o);
    end
  endtask

  task automatic test_nominal();
    bit seen;
    logic signed [4:0] got, exp;
    ref_edge();
    cycles(6);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL first_ref_no_strobe: got %0d strobes expected 0", obs_q.size());
      obs_q.delete();
    end
    for (int p = 0; p < 3; p++) begin
      fb_edges(16);
      expect_err(16, 16);
      ref_edge();
      take_result(seen, got, exp);
      tests_run++;
      if (!seen || got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL nominal_err[%0d]: got %0d (strobe %0b) expected %0d", p, got, seen, exp);
      end
    end
  endtask

  task automatic test_slow_fast();
    bit seen;
    logic signed [4:0] got, exp;
    int fb_tab[2] = '{14, 19};
    for (int p = 0; p < 2; p++) begin
      fb_edges(fb_tab[p]);
      expect_err(16, fb_tab[p]);
      ref_edge();
      take_result(seen, got, exp);
      tests_run++;
      if (!seen || got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL slow_fast_err[%0d]: got %0d (strobe %0b) expected %0d", p, got, seen, exp);
      end
    end
  endtask

  task automatic test_dynamic_target();
    bit seen;
    logic signed [4:0] got, exp;
    fb_edges(5);
    n_target_i = 8'd20;
    fb_edges(13);
    expect_err(20, 18);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL dynamic_target: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
    n_target_i = 8'd16;
  endtask

  task automatic test_saturation();
    bit seen;
    logic signed [4:0] got, exp;
    expect_err(16, 0);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL sat_zero_fb: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
    fb_edges(10);
    tests_run++;
    if (error_o !== exp) begin
      tests_failed++;
      $display("[TB] FAIL error_hold: got %0d expected %0d", error_o, exp);
    end
    fb_edges(50);
    expect_err(16, 60);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL sat_60_fb: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
    n_target_i = 8'd255;
    fb_edges(270);
    expect_err(255, 270);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL counter_saturate: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
    n_target_i = 8'd16;
    fb_edges(300);
    expect_err(16, 300);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL sat_300_fb: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
  endtask

  task automatic test_coincident();
    bit seen;
    logic signed [4:0] got, exp;
    fb_edges(15);
    expect_err(16, 16);
    fb_i = 1'b1;
    ref_i = 1'b1;
    cycles(2);
    fb_i = 1'b0;
    ref_i = 1'b0;
    cycles(2);
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL coincident_close: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
    fb_edges(16);
    expect_err(16, 16);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL coincident_next: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
  endtask

  task automatic test_lock();
    bit seen;
    logic signed [4:0] got, exp;
    int fb_tab[5] = '{16, 15, 17, 16, 13};
    int lcnt = 0;
    bit lock_before;
    bit lock_after = 1'b0;
    do_reset(1);
    ref_edge();
    for (int p = 0; p < 5; p++) begin
      fb_edges(fb_tab[p]);
      expect_err(16, fb_tab[p]);
      exp = model_err(16, fb_tab[p]);
      lock_before = lock_after;
      if (exp >= -5'sd1 && exp <= 5'sd1) lcnt = (lcnt < 4) ? lcnt + 1 : 4;
      else lcnt = 0;
      lock_after = LOCK_EN && (lcnt == 4);
      ref_edge();
      tests_run++;
      if (lock_o !== lock_before) begin
        tests_failed++;
        $display("[TB] FAIL lock_on_strobe[%0d]: got %0b expected %0b", p, lock_o, lock_before);
      end
      cycles(1);
      tests_run++;
      if (lock_o !== lock_after) begin
        tests_failed++;
        $display("[TB] FAIL lock_after_strobe[%0d]: got %0b expected %0b", p, lock_o, lock_after);
      end
      take_result(seen, got, exp);
      tests_run++;
      if (!seen || got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL lock_err[%0d]: got %0d (strobe %0b) expected %0d", p, got, seen, exp);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    bit seen;
    logic signed [4:0] got, exp;
    fb_edges(8);
    do_reset(1);
    tests_run++;
    if (error_o !== 5'sd0 || error_valid_o !== 1'b0 || lock_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: got err=%0d valid=%0b lock=%0b expected 0/0/0",
               error_o, error_valid_o, lock_o);
    end
    fb_edges(3);
    ref_edge();
    cycles(8);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_no_strobe: got %0d strobes expected 0", obs_q.size());
      obs_q.delete();
    end
    fb_edges(14);
    expect_err(16, 14);
    ref_edge();
    take_result(seen, got, exp);
    tests_run++;
    if (!seen || got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_second_ref: got %0d (strobe %0b) expected %0d", got, seen, exp);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic signed [4:0] got, exp;
    for (int p = 0; p < 2; p++) begin
      expect_err(16, 0);
      ref_edge();
      take_result(seen, got, exp);
      tests_run++;
      if (!seen || got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back[%0d]: got %0d (strobe %0b) expected %0d", p, got, seen, exp);
      end
    end
    cycles(10);
    tests_run++;
    if (long_strobes != 0) begin
      tests_failed++;
      $display("[TB] FAIL strobe_width: got %0d multi-cycle strobes expected 0", long_strobes);
    end
    tests_run++;
    if (strobes_seen != strobes_expected || obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL strobe_count: got %0d strobes (%0d unmatched) expected %0d",
               strobes_seen, obs_q.size(), strobes_expected);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_slow_fast();
    test_dynamic_target();
    test_saturation();
    test_coincident();
    test_lock();
    test_reset_mid_period();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
